hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
Pipeline hazard controller for the 5-stage RV32I core. It works alongside operand forwarding and covers the hazards forwarding cannot resolve:
- load-use stalls;
- scoreboarding for the multi-cycle mul/div unit (MDU);
- control-flow flush on taken branch/jump.
It drives stall/flush/bubble controls for the IF/ID/EX pipeline registers and keeps a stall-cycle performance counter.

Parameters:
NUM_REGS, 32, architectural register count; scoreboard depth; x0 never tracked.
MDU_MAX_OUTSTANDING, 1, maximum in-flight MDU operations (supported values 1..4).
CNT_WIDTH, 32, width of stall_cycles counter.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous active-high reset
rs1_id  in  5  rs1 of instruction in ID
rs2_id  in  5  rs2 of instruction in ID
rs1_used_id  in  1  ID instruction reads rs1
rs2_used_id  in  1  ID instruction reads rs2
rd_id  in  5  rd of instruction in ID
reg_write_id  in  1  ID instruction writes rd
is_mdu_id  in  1  ID instruction is mul/div
rd_ex  in  5  rd of instruction in EX
mem_read_ex  in  1  EX instruction is a load
mdu_issue_ex  in  1  MDU op accepted from EX this cycle
mdu_wb_valid  in  1  MDU result written back this cycle
mdu_wb_rd  in  5  rd of MDU writeback
branch_taken_ex  in  1  taken branch/jump resolved in EX
stall_if  out  1  hold PC and IF/ID register
stall_id  out  1  hold ID stage
bubble_ex  out  1  insert NOP into ID/EX
flush_if  out  1  squash IF/ID contents
flush_id  out  1  squash ID/EX contents
mdu_busy  out  1  outstanding count == MDU_MAX_OUTSTANDING
stall_cycles  out  CNT_WIDTH  cycles with stall_id asserted

Behaviour:
- State:
  - pending[NUM_REGS-1:0] scoreboard.
  - out_cnt outstanding-MDU counter, width clog2(MDU_MAX_OUTSTANDING+1).
  - stall_cycles counter.
- Reset (async, high):
  - pending=0, out_cnt=0, stall_cycles=0.
  - All control outputs 0 while reset is asserted.
- Load-use hazard (combinational):
  - lu = mem_read_ex & rd_ex!=0 & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)).
- Scoreboard hazard (combinational):
  - sb = (rs1_used_id & pending[rs1_id]) | (rs2_used_id & pending[rs2_id]) | (reg_write_id & rd_id!=0 & pending[rd_id]).
  - The rd_id term is the WAW check.
- MDU structural hazard: st = is_mdu_id & mdu_busy.
- Hazard resolution, with hz = lu|sb|st:
  - stall_if = stall_id = bubble_ex = hz & ~branch_taken_ex.
  - Load-use stall lasts exactly 1 cycle. Next cycle the load is in MEM and forwarding resolves it.
- Flush:
  - flush_if = flush_id = branch_taken_ex.
  - Branch has priority: all stalls are deasserted in that cycle because the ID instruction is squashed.
- Scoreboard update (posedge):
  - Set pending[rd_ex] on mdu_issue_ex when rd_ex!=0.
  - Clear pending[mdu_wb_rd] on mdu_wb_valid.
  - Same-register set and clear in the same cycle: set wins, since the new op is younger.
  - pending[0] is always 0.
- Writeback bypass:
  - A clear in cycle N is visible to the combinational hazard in cycle N, i.e. pending is masked with the writeback.
  - The ID instruction therefore issues in the same cycle as the MDU writeback (WB->ID forward path exists).
- out_cnt:
  - +1 on mdu_issue_ex, -1 on mdu_wb_valid; both in one cycle = no change.
  - Saturates: issue at MAX or writeback at 0 is ignored.
  - mdu_busy = (out_cnt == MDU_MAX_OUTSTANDING), registered-state derived.
- stall_cycles:
  - Increments each cycle stall_id=1.
  - Wraps at 2^CNT_WIDTH.
- Branch taken while an MDU op is pending:
  - The scoreboard is NOT cleared; the in-flight MDU op is older and must retire.
- Reset mid-operation:
  - Clears all pending bits and out_cnt immediately.
  - Later mdu_wb_valid pulses are harmless due to saturation and idempotent clears.

Test Plan:
- Load x5 in EX (mem_read_ex=1, rd_ex=5), ID add reads rs1=5 -> stall_if/stall_id/bubble_ex=1 for exactly 1 cycle; stall_cycles 0->1.
- Load with rd_ex=0, ID rs1=0 -> no stall. Load rd_ex=7, ID rs2=7 with rs2_used_id=0 -> no stall.
- mdu_issue_ex rd_ex=10, then ID reads x10 for 6 cycles, mdu_wb_valid rd=10 on cycle 7 -> stall 6 cycles, released in cycle 7; pending[10]=0 after.
- MAX_OUTSTANDING=1: issue MDU rd=3, ID is_mdu_id=1 rd=4 -> mdu_busy=1, stall until writeback; issue+writeback same cycle keeps out_cnt=1.
- Load-use hazard and branch_taken_ex same cycle -> flush_if=flush_id=1, stall/bubble=0.
- Pending x8, assert reset mid-stall -> all outputs 0, pending cleared; after release, ID reading x8 issues with no stall.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, MDU register scoreboard with
// writeback bypass, MDU occupancy tracking, branch flush and a stall counter.
module hazard_control_unit #(
   parameter int NUM_REGS            = 32,
   parameter int MDU_MAX_OUTSTANDING = 1,
   parameter int CNT_WIDTH           = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           rs1_id,
   input  logic [4:0]           rs2_id,
   input  logic                 rs1_used_id,
   input  logic                 rs2_used_id,
   input  logic [4:0]           rd_id,
   input  logic                 reg_write_id,
   input  logic                 is_mdu_id,
   input  logic [4:0]           rd_ex,
   input  logic                 mem_read_ex,
   input  logic                 mdu_issue_ex,
   input  logic                 mdu_wb_valid,
   input  logic [4:0]           mdu_wb_rd,
   input  logic                 branch_taken_ex,
   output logic                 stall_if,
   output logic                 stall_id,
   output logic                 bubble_ex,
   output logic                 flush_if,
   output logic                 flush_id,
   output logic                 mdu_busy,
   output logic [CNT_WIDTH-1:0] stall_cycles
);

   localparam int OCW = $clog2(MDU_MAX_OUTSTANDING + 1);
   localparam logic [OCW-1:0] OC_MAX = OCW'(MDU_MAX_OUTSTANDING);

   logic [NUM_REGS-1:0]  r_pending;
   logic [NUM_REGS-1:0]  w_pending_next;
   logic [NUM_REGS-1:0]  w_pend_eff;
   logic [NUM_REGS-1:0]  w_rs1_hit;
   logic [NUM_REGS-1:0]  w_rs2_hit;
   logic [NUM_REGS-1:0]  w_rd_hit;
   logic [OCW-1:0]       r_out_cnt;
   logic [OCW-1:0]       w_out_cnt_next;
   logic [CNT_WIDTH-1:0] r_stall_cycles;
   logic                 w_lu;
   logic                 w_sb;
   logic                 w_st;
   logic                 w_stall;

   // A set always beats a clear on the same register: the issuing op is younger.
   // x0 can never be set, so its bit stays at its reset value of zero.
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
         localparam logic [4:0] IDX = 5'(gi);
         logic w_set;
         logic w_clr;
         assign w_set             = mdu_issue_ex & (rd_ex != 5'd0) & (rd_ex == IDX);
         assign w_clr             = mdu_wb_valid & (mdu_wb_rd == IDX);
         assign w_pending_next[gi] = w_set | (r_pending[gi] & ~w_clr);
         // The writeback is forwarded to ID, so a retiring register no longer blocks.
         assign w_pend_eff[gi]    = r_pending[gi] & ~w_clr;
         assign w_rs1_hit[gi]     = (rs1_id == IDX) & w_pend_eff[gi];
         assign w_rs2_hit[gi]     = (rs2_id == IDX) & w_pend_eff[gi];
         assign w_rd_hit[gi]      = (rd_id  == IDX) & w_pend_eff[gi];
      end
   endgenerate

   assign w_lu = mem_read_ex & (rd_ex != 5'd0) &
                 ((rs1_used_id & (rs1_id == rd_ex)) | (rs2_used_id & (rs2_id == rd_ex)));
   assign w_sb = (rs1_used_id & (|w_rs1_hit)) | (rs2_used_id & (|w_rs2_hit)) |
                 (reg_write_id & (rd_id != 5'd0) & (|w_rd_hit));
   assign w_st = is_mdu_id & mdu_busy;

   // A taken branch squashes the ID instruction, so its hazards are moot.
   assign w_stall = (w_lu | w_sb | w_st) & ~branch_taken_ex & ~reset;

   assign stall_if     = w_stall;
   assign stall_id     = w_stall;
   assign bubble_ex    = w_stall;
   assign flush_if     = branch_taken_ex & ~reset;
   assign flush_id     = branch_taken_ex & ~reset;
   assign mdu_busy     = (r_out_cnt == OC_MAX);
   assign stall_cycles = r_stall_cycles;

   always_comb begin
      w_out_cnt_next = r_out_cnt;
      if (mdu_issue_ex && !mdu_wb_valid && (r_out_cnt != OC_MAX)) begin
         w_out_cnt_next = r_out_cnt + OCW'(1);
      end else if (mdu_wb_valid && !mdu_issue_ex && (r_out_cnt != '0)) begin
         w_out_cnt_next = r_out_cnt - OCW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pending      <= '0;
         r_out_cnt      <= '0;
         r_stall_cycles <= '0;
      end else begin
         r_pending      <= w_pending_next;
         r_out_cnt      <= w_out_cnt_next;
         r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(w_stall);
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_hazard_control_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  rs1_id, rs2_id, rd_id, rd_ex, mdu_wb_rd;
   logic        rs1_used_id, rs2_used_id, reg_write_id, is_mdu_id;
   logic        mem_read_ex, mdu_issue_ex, mdu_wb_valid, branch_taken_ex;
   logic        stall_if, stall_id, bubble_ex, flush_if, flush_id, mdu_busy;
   logic [31:0] stall_cycles;

   int tests_run = 0;
   int tests_failed = 0;

   string       name_q[$];
   logic [5:0]  ctl_q[$];
   logic [31:0] cnt_q[$];

   always #5 clk = ~clk;

   hazard_control_unit #(
      .NUM_REGS(32), .MDU_MAX_OUTSTANDING(1), .CNT_WIDTH(32)
   ) dut (
      .clk(clk), .reset(reset),
      .rs1_id(rs1_id), .rs2_id(rs2_id),
      .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
      .rd_id(rd_id), .reg_write_id(reg_write_id), .is_mdu_id(is_mdu_id),
      .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .mdu_issue_ex(mdu_issue_ex),
      .mdu_wb_valid(mdu_wb_valid), .mdu_wb_rd(mdu_wb_rd),
      .branch_taken_ex(branch_taken_ex),
      .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
      .flush_if(flush_if), .flush_id(flush_id), .mdu_busy(mdu_busy),
      .stall_cycles(stall_cycles)
   );

   // ctl encoding: {stall_if, stall_id, bubble_ex, flush_if, flush_id, mdu_busy}
   localparam logic [5:0] C_IDLE  = 6'b000000;
   localparam logic [5:0] C_BUSY  = 6'b000001;
   localparam logic [5:0] C_STALL = 6'b111000;
   localparam logic [5:0] C_STB   = 6'b111001;
   localparam logic [5:0] C_FLUSH = 6'b000110;
   localparam logic [5:0] C_FLB   = 6'b000111;

   task automatic idle();
      rs1_id = 0; rs2_id = 0; rd_id = 0; rd_ex = 0; mdu_wb_rd = 0;
      rs1_used_id = 0; rs2_used_id = 0; reg_write_id = 0; is_mdu_id = 0;
      mem_read_ex = 0; mdu_issue_ex = 0; mdu_wb_valid = 0; branch_taken_ex = 0;
   endtask

   task automatic expect_cyc(input string n, input logic [5:0] c, input logic [31:0] k);
      name_q.push_back(n);
      ctl_q.push_back(c);
      cnt_q.push_back(k);
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      string      n;
      logic [5:0] c, act;
      logic [31:0] k;
      forever begin
         @(negedge clk);
         if (name_q.size() > 0) begin
            n = name_q.pop_front();
            c = ctl_q.pop_front();
            k = cnt_q.pop_front();
            act = {stall_if, stall_id, bubble_ex, flush_if, flush_id, mdu_busy};
            tests_run++;
            if (act !== c) begin
               tests_failed++;
               $display("FAIL %s ctl actual=%b required=%b", n, act, c);
            end
            tests_run++;
            if (stall_cycles !== k) begin
               tests_failed++;
               $display("FAIL %s stall_cycles actual=%0d required=%0d", n, stall_cycles, k);
            end
            if (act === c && stall_cycles === k)
               $display("[TB] %s ok ctl=%b cnt=%0d", n, act, stall_cycles);
         end
      end
   end

   initial begin : driver
      idle();
      @(posedge clk); #1;
      // Reset held with hazard inputs active: everything must read zero
      idle(); mem_read_ex = 1; rd_ex = 5; rs1_id = 5; rs1_used_id = 1; branch_taken_ex = 1;
      expect_cyc("reset_hold", C_IDLE, 0);
      idle(); reset = 0; mem_read_ex = 1; rd_ex = 5; rs1_id = 5; rs1_used_id = 1;
      expect_cyc("lu_rs1", C_STALL, 0);
      idle();
      expect_cyc("lu_released", C_IDLE, 1);
      idle(); mem_read_ex = 1; rd_ex = 0; rs1_id = 0; rs1_used_id = 1;
      expect_cyc("lu_x0", C_IDLE, 1);
      idle(); mem_read_ex = 1; rd_ex = 7; rs2_id = 7; rs2_used_id = 0;
      expect_cyc("lu_rs2_unused", C_IDLE, 1);
      idle(); mem_read_ex = 1; rd_ex = 7; rs2_id = 7; rs2_used_id = 1;
      expect_cyc("lu_rs2", C_STALL, 1);
      // MDU to x10, RAW wait of six cycles, released on writeback
      idle(); mdu_issue_ex = 1; rd_ex = 10;
      expect_cyc("mdu_issue10", C_IDLE, 2);
      for (int i = 0; i < 6; i++) begin
         idle(); rs1_id = 10; rs1_used_id = 1;
         expect_cyc($sformatf("sb_raw10_%0d", i), C_STB, 32'(2 + i));
      end
      idle(); rs1_id = 10; rs1_used_id = 1; mdu_wb_valid = 1; mdu_wb_rd = 10;
      expect_cyc("sb_wb_bypass", C_BUSY, 8);
      idle(); rs1_id = 10; rs1_used_id = 1;
      expect_cyc("sb_cleared10", C_IDLE, 8);
      // Structural and WAW hazards with one outstanding op to x3
      idle(); mdu_issue_ex = 1; rd_ex = 3;
      expect_cyc("mdu_issue3", C_IDLE, 8);
      idle(); is_mdu_id = 1; reg_write_id = 1; rd_id = 4;
      expect_cyc("st_busy", C_STB, 8);
      idle(); reg_write_id = 1; rd_id = 3;
      expect_cyc("waw3", C_STB, 9);
      idle(); mdu_issue_ex = 1; rd_ex = 6; mdu_wb_valid = 1; mdu_wb_rd = 3;
      expect_cyc("iss_wb_same", C_BUSY, 10);
      idle(); rs1_id = 3; rs1_used_id = 1;
      expect_cyc("busy_kept_x3_free", C_BUSY, 10);
      idle(); rs2_id = 6; rs2_used_id = 1;
      expect_cyc("pend6_rs2", C_STB, 10);
      idle(); mdu_issue_ex = 1; rd_ex = 6; mdu_wb_valid = 1; mdu_wb_rd = 6;
      expect_cyc("set_clr_same", C_BUSY, 11);
      idle(); rs1_id = 6; rs1_used_id = 1;
      expect_cyc("set_wins6", C_STB, 11);
      idle(); mdu_wb_valid = 1; mdu_wb_rd = 6;
      expect_cyc("wb6", C_BUSY, 12);
      idle(); mdu_wb_valid = 1; mdu_wb_rd = 6;
      expect_cyc("wb_at_zero", C_IDLE, 12);
      idle(); is_mdu_id = 1; reg_write_id = 1; rd_id = 9;
      expect_cyc("no_underflow", C_IDLE, 12);
      // Branch priority
      idle(); mem_read_ex = 1; rd_ex = 5; rs1_id = 5; rs1_used_id = 1; branch_taken_ex = 1;
      expect_cyc("lu_branch", C_FLUSH, 12);
      idle(); mdu_issue_ex = 1; rd_ex = 8;
      expect_cyc("mdu_issue8", C_IDLE, 12);
      idle(); rs1_id = 8; rs1_used_id = 1; branch_taken_ex = 1;
      expect_cyc("branch_pend8", C_FLB, 12);
      idle(); rs1_id = 8; rs1_used_id = 1;
      expect_cyc("pend8_kept", C_STB, 12);
      // Reset in the middle of a scoreboard stall
      idle(); reset = 1; rs1_id = 8; rs1_used_id = 1; mem_read_ex = 1; rd_ex = 8;
      expect_cyc("reset_mid", C_IDLE, 0);
      idle(); reset = 0; rs1_id = 8; rs1_used_id = 1;
      expect_cyc("post_reset_x8", C_IDLE, 0);
      idle(); mdu_wb_valid = 1; mdu_wb_rd = 8;
      expect_cyc("late_wb8", C_IDLE, 0);
      idle(); is_mdu_id = 1;
      expect_cyc("cnt_stays0", C_IDLE, 0);
      // x0 destination occupies the unit but is never tracked
      idle(); mdu_issue_ex = 1; rd_ex = 0;
      expect_cyc("mdu_issue_x0", C_IDLE, 0);
      idle(); rs1_id = 0; rs1_used_id = 1; reg_write_id = 1; rd_id = 0;
      expect_cyc("x0_untracked", C_BUSY, 0);
      idle();
      for (int i = 0; i < 10 && name_q.size() > 0; i++) @(posedge clk);
      if (name_q.size() > 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL drain queue_left=%0d required=0", name_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog timeout actual=expired required=finish");
      $fatal(1, "timeout");
   end

endmodule
